mem_access_unit: RTL and testbench

MEM-stage load/store engine, directly downstream of the EX-stage ALU. Consumes the ALU's effective address (`a + signed_extend`), its op code and exception code, plus the store operand. Drives one blocking transaction at a time on the SRAM-like data-cache port, generating byte strobes for stores and aligning and extending load data. Holds the pipeline with `stall` until the access completes.

---
 rtl/mem_pkg.sv | 46 ++++
 rtl/mem_access_unit_load_align.sv | 27 ++
 rtl/mem_access_unit.sv | 151 +++++++++++++++
 tb/tb_mem_access_unit.sv | 347 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_pkg.sv
// Shared types, op codes and helpers for the MEM-stage load/store engine.
package mem_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_REQ   = 2'd1,
    ST_WAIT  = 2'd2,
    ST_DRAIN = 2'd3
  } mem_state_t;

  localparam logic [1:0] SZ_BYTE = 2'd0;
  localparam logic [1:0] SZ_HALF = 2'd1;
  localparam logic [1:0] SZ_WORD = 2'd2;

  // ALU op codes shared with the EX stage.
  localparam logic [5:0] ALU_ADD = 6'd0;
  localparam logic [5:0] ALU_LB  = 6'd16;
  localparam logic [5:0] ALU_LBU = 6'd17;
  localparam logic [5:0] ALU_LH  = 6'd18;
  localparam logic [5:0] ALU_LHU = 6'd19;
  localparam logic [5:0] ALU_LW  = 6'd20;
  localparam logic [5:0] ALU_SB  = 6'd21;
  localparam logic [5:0] ALU_SH  = 6'd22;
  localparam logic [5:0] ALU_SW  = 6'd23;

  function automatic logic is_mem_op(input logic [5:0] op);
    case (op)
      ALU_LB, ALU_LBU, ALU_LH, ALU_LHU, ALU_LW,
      ALU_SB, ALU_SH, ALU_SW: is_mem_op = 1'b1;
      default:                is_mem_op = 1'b0;
    endcase
  endfunction

  function automatic logic is_store(input logic [5:0] op);
    is_store = (op == ALU_SB) || (op == ALU_SH) || (op == ALU_SW);
  endfunction

  function automatic logic [1:0] op_size(input logic [5:0] op);
    case (op)
      ALU_LB, ALU_LBU, ALU_SB: op_size = SZ_BYTE;
      ALU_LH, ALU_LHU, ALU_SH: op_size = SZ_HALF;
      default:                 op_size = SZ_WORD;
    endcase
  endfunction

endpackage

// File: rtl/mem_access_unit_load_align.sv
// Selects the addressed byte/halfword lane of a raw read word and extends it.
module load_align
  import mem_pkg::*;
(
  input  logic [5:0]  op,
  input  logic [1:0]  addr_lo,
  input  logic [31:0] rdata,
  output logic [31:0] load_data
);

  logic [7:0]  lane_b;
  logic [15:0] lane_h;

  always_comb begin
    lane_b = rdata[{addr_lo, 3'b000} +: 8];
    lane_h = addr_lo[1] ? rdata[31:16] : rdata[15:0];
    case (op)
      ALU_LB:  load_data = {{24{lane_b[7]}}, lane_b};
      ALU_LBU: load_data = {24'd0, lane_b};
      ALU_LH:  load_data = {{16{lane_h[15]}}, lane_h};
      ALU_LHU: load_data = {16'd0, lane_h};
      ALU_LW:  load_data = rdata;
      default: load_data = 32'd0;
    endcase
  end

endmodule

// File: rtl/mem_access_unit.sv
// MEM-stage load/store engine: one blocking transaction at a time on an SRAM-like
// data-cache port. Handshake: req/fields held until addr_ok; data_ok ends the access.
module mem_access_unit
  import mem_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        valid_i,
  input  logic [5:0]  op_i,
  input  logic [31:0] addr_i,
  input  logic [31:0] wdata_i,
  input  logic [3:0]  exception_i,
  input  logic        flush_i,
  output logic        req,
  output logic        wr,
  output logic [1:0]  size,
  output logic [31:0] addr,
  output logic [31:0] wdata,
  output logic [3:0]  wstrb,
  input  logic        addr_ok,
  input  logic        data_ok,
  input  logic [31:0] rdata,
  output logic [31:0] load_data,
  output logic        done,
  output logic        stall,
  output logic [1:0]  dbg_state
);

  mem_state_t  state_q, state_d;
  logic [5:0]  op_q, op_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic        kill_q, kill_d;
  logic        go;
  logic [5:0]  cur_op;
  logic [31:0] cur_addr, cur_wdata;
  logic [31:0] aligned;

  // rst in go keeps every output low while reset is asserted.
  assign go        = valid_i & is_mem_op(op_i) & (exception_i == 4'd0) & ~flush_i & rst;
  assign dbg_state = state_q;

  always_comb begin
    state_d   = state_q;
    op_d      = op_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    kill_d    = kill_q;
    req       = 1'b0;
    done      = 1'b0;
    stall     = 1'b0;
    cur_op    = op_q;
    cur_addr  = addr_q;
    cur_wdata = wdata_q;
    case (state_q)
      ST_IDLE: begin
        cur_op    = op_i;
        cur_addr  = addr_i;
        cur_wdata = wdata_i;
        req       = go;
        stall     = go;
        kill_d    = 1'b0;
        if (go) begin
          op_d    = op_i;
          addr_d  = addr_i;
          wdata_d = wdata_i;
          state_d = addr_ok ? ST_WAIT : ST_REQ;
        end
      end
      ST_REQ: begin
        req   = 1'b1;
        stall = ~flush_i;
        if (addr_ok) begin
          state_d = ST_WAIT;
          kill_d  = flush_i;
        end else if (flush_i) begin
          state_d = ST_IDLE;
        end
      end
      ST_WAIT: begin
        // kill_q marks an access accepted in the same cycle it was flushed.
        stall = (~data_ok & ~flush_i) | (kill_q & go);
        if (data_ok) begin
          state_d = ST_IDLE;
          done    = ~(flush_i | kill_q);
        end else if (flush_i | kill_q) begin
          state_d = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        stall = go;
        if (data_ok) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    wr    = 1'b0;
    size  = SZ_BYTE;
    addr  = 32'd0;
    wdata = 32'd0;
    wstrb = 4'd0;
    if (req) begin
      wr   = is_store(cur_op);
      size = op_size(cur_op);
      addr = cur_addr;
      case (cur_op)
        ALU_SB: begin
          wdata = {4{cur_wdata[7:0]}};
          wstrb = 4'b0001 << cur_addr[1:0];
        end
        ALU_SH: begin
          wdata = {2{cur_wdata[15:0]}};
          wstrb = cur_addr[1] ? 4'b1100 : 4'b0011;
        end
        ALU_SW: begin
          wdata = cur_wdata;
          wstrb = 4'b1111;
        end
        default: ;
      endcase
    end
  end

  load_align u_load_align (
    .op        (op_q),
    .addr_lo   (addr_q[1:0]),
    .rdata     (rdata),
    .load_data (aligned)
  );

  assign load_data = done ? aligned : 32'd0;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_IDLE;
      op_q    <= 6'd0;
      addr_q  <= 32'd0;
      wdata_q <= 32'd0;
      kill_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      kill_q  <= kill_d;
    end
  end

endmodule

// File: tb/tb_mem_access_unit.sv
// Bench for mem_access_unit: directed cases, then random traffic against a reference model.
`timescale 1ns/1ps
module tb_mem_access_unit;
  import mem_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        valid_i = 1'b0;
  logic [5:0]  op_i = 6'd0;
  logic [31:0] addr_i = 32'd0;
  logic [31:0] wdata_i = 32'd0;
  logic [3:0]  exception_i = 4'd0;
  logic        flush_i = 1'b0;
  logic        addr_ok = 1'b0;
  logic        data_ok = 1'b0;
  logic [31:0] rdata = 32'd0;
  logic        req, wr, done, stall;
  logic [1:0]  size, dbg_state;
  logic [31:0] addr, wdata, load_data;
  logic [3:0]  wstrb;

  mem_access_unit dut (
    .clk(clk), .rst(rst), .valid_i(valid_i), .op_i(op_i), .addr_i(addr_i),
    .wdata_i(wdata_i), .exception_i(exception_i), .flush_i(flush_i),
    .req(req), .wr(wr), .size(size), .addr(addr), .wdata(wdata), .wstrb(wstrb),
    .addr_ok(addr_ok), .data_ok(data_ok), .rdata(rdata),
    .load_data(load_data), .done(done), .stall(stall), .dbg_state(dbg_state)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  int n_chk = 0;
  int n_pass = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic fail(input string name);
    n_chk++;
    $display("FAIL %s: got event expected none", name);
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // ---------------- reference model ----------------
  typedef struct packed {
    logic        wr;
    logic [1:0]  size;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
  } req_t;

  function automatic req_t model_req(input logic [5:0] op, input logic [31:0] a, input logic [31:0] wd);
    req_t r;
    int   lane;
    lane    = int'(a % 32'd4);
    r.addr  = a;
    r.wr    = 1'b0;
    r.wdata = 32'd0;
    r.wstrb = 4'd0;
    if (op == ALU_LB || op == ALU_LBU || op == ALU_SB) r.size = 2'd0;
    else if (op == ALU_LH || op == ALU_LHU || op == ALU_SH) r.size = 2'd1;
    else r.size = 2'd2;
    if (op == ALU_SB) begin
      r.wr = 1'b1; r.wdata = {24'd0, wd[7:0]} * 32'h01010101; r.wstrb = 4'(1 << lane);
    end else if (op == ALU_SH) begin
      r.wr = 1'b1; r.wdata = {16'd0, wd[15:0]} * 32'h00010001; r.wstrb = (lane >= 2) ? 4'hC : 4'h3;
    end else if (op == ALU_SW) begin
      r.wr = 1'b1; r.wdata = wd; r.wstrb = 4'hF;
    end
    return r;
  endfunction

  function automatic logic [31:0] model_load(input logic [5:0] op, input logic [31:0] a, input logic [31:0] rd);
    logic [31:0] s;
    s = rd >> (8 * (a % 32'd4));
    case (op)
      ALU_LB:  return 32'($signed(s[7:0]));
      ALU_LBU: return {24'd0, s[7:0]};
      ALU_LH:  return 32'($signed(s[15:0]));
      ALU_LHU: return {16'd0, s[15:0]};
      default: return rd;
    endcase
  endfunction

  req_t        req_q[$];
  logic [5:0]  lop_q[$];
  logic [31:0] la_q[$];
  logic [32:0] exp_q[$];
  logic [5:0]  mem_ops[8] = '{ALU_LB, ALU_LBU, ALU_LH, ALU_LHU, ALU_LW, ALU_SB, ALU_SH, ALU_SW};
  bit          resp_auto = 1'b0;
  bit          sb_on = 1'b0;

  // ---------------- random cache responder ----------------
  int pend = 0;
  int dly = 0;
  always @(posedge clk) begin
    logic [5:0]  o;
    logic [31:0] a;
    #2;
    if (resp_auto) begin
      addr_ok = 1'b0;
      data_ok = 1'b0;
      if (pend != 0) begin
        if (dly == 0) begin
          data_ok = 1'b1;
          rdata   = $urandom;
          pend    = 0;
          if (lop_q.size() > 0) begin
            o = lop_q.pop_front();
            a = la_q.pop_front();
            exp_q.push_back({~is_store(o), model_load(o, a, rdata)});
          end
        end else dly--;
      end else if (req && $urandom_range(0, 2) != 0) begin
        addr_ok = 1'b1;
        pend    = 1;
        dly     = $urandom_range(0, 2);
      end
    end
  end

  // ---------------- scoreboard monitor ----------------
  always @(negedge clk) begin
    req_t        e;
    logic [32:0] x;
    if (sb_on) begin
      if (req && addr_ok) begin
        if (req_q.size() == 0) fail("unexpected_req");
        else begin
          e = req_q.pop_front();
          chk("sb_addr", addr, e.addr);
          chk("sb_wr", {31'd0, wr}, {31'd0, e.wr});
          chk("sb_size", {30'd0, size}, {30'd0, e.size});
          chk("sb_wstrb", {28'd0, wstrb}, {28'd0, e.wstrb});
          if (e.wr) chk("sb_wdata", wdata, e.wdata);
        end
      end
      if (done) begin
        if (exp_q.size() == 0) fail("unexpected_done");
        else begin
          x = exp_q.pop_front();
          if (x[32]) chk("sb_load_data", load_data, x[31:0]);
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  logic        c_req, c_wr, c_stall1, c_done1, c_done2, c_stall2, c_done3, c_req3;
  logic [1:0]  c_size;
  logic [31:0] c_addr, c_wdata, c_ld;
  logic [3:0]  c_wstrb;

  task automatic run_best(input logic [5:0] op, input logic [31:0] a, input logic [31:0] wd, input logic [31:0] rd);
    cyc();
    valid_i = 1'b1; op_i = op; addr_i = a; wdata_i = wd; addr_ok = 1'b1;
    @(negedge clk);
    c_req = req; c_wr = wr; c_size = size; c_addr = addr; c_wdata = wdata;
    c_wstrb = wstrb; c_stall1 = stall; c_done1 = done;
    cyc();
    addr_ok = 1'b0; data_ok = 1'b1; rdata = rd;
    @(negedge clk);
    c_done2 = done; c_ld = load_data; c_stall2 = stall;
    cyc();
    valid_i = 1'b0; data_ok = 1'b0;
    @(negedge clk);
    c_done3 = done; c_req3 = req;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    #3;
    chk("reset_ctrl", {22'd0, req, wr, done, stall, size, wstrb, dbg_state}, 32'd0);
    chk("reset_addr", addr, 32'd0);
    chk("reset_wdata", wdata, 32'd0);
    chk("reset_load_data", load_data, 32'd0);
    cyc();
    rst = 1'b1;

    run_best(ALU_LW, 32'h1000, 32'd0, 32'hDEADBEEF);
    chk("lw_req", {31'd0, c_req}, 32'd1);
    chk("lw_size", {30'd0, c_size}, 32'd2);
    chk("lw_wstrb", {28'd0, c_wstrb}, 32'd0);
    chk("lw_stall_c1", {31'd0, c_stall1}, 32'd1);
    chk("lw_done_c1", {31'd0, c_done1}, 32'd0);
    chk("lw_done_c2", {31'd0, c_done2}, 32'd1);
    chk("lw_load_data", c_ld, 32'hDEADBEEF);
    chk("lw_stall_c2", {31'd0, c_stall2}, 32'd0);
    chk("lw_done_c3", {31'd0, c_done3}, 32'd0);
    chk("lw_req_c3", {31'd0, c_req3}, 32'd0);

    run_best(ALU_SB, 32'h1003, 32'h000000A5, 32'd0);
    chk("sb_wstrb_d", {28'd0, c_wstrb}, 32'h8);
    chk("sb_wdata_d", c_wdata, 32'hA5A5A5A5);
    chk("sb_size_d", {30'd0, c_size}, 32'd0);
    chk("sb_wr_d", {31'd0, c_wr}, 32'd1);
    chk("sb_addr_d", c_addr, 32'h1003);
    chk("sb_done", {31'd0, c_done2}, 32'd1);

    run_best(ALU_LB, 32'h2001, 32'd0, 32'h00008000);
    chk("lb_sext", c_ld, 32'hFFFFFF80);
    run_best(ALU_LBU, 32'h2001, 32'd0, 32'h00008000);
    chk("lbu_zext", c_ld, 32'h00000080);
    run_best(ALU_LH, 32'h2002, 32'd0, 32'h80010000);
    chk("lh_sext", c_ld, 32'hFFFF8001);
    run_best(ALU_SH, 32'h2002, 32'h0000BEEF, 32'd0);
    chk("sh_wstrb", {28'd0, c_wstrb}, 32'hC);
    chk("sh_wdata", c_wdata, 32'hBEEFBEEF);

    // addr_ok withheld for three cycles
    for (int k = 0; k < 4; k++) begin
      cyc();
      if (k == 0) begin valid_i = 1'b1; op_i = ALU_SW; addr_i = 32'h3000; wdata_i = 32'h12345678; end
      addr_ok = (k == 3);
      @(negedge clk);
      chk($sformatf("hold_req_%0d", k), {31'd0, req}, 32'd1);
      chk($sformatf("hold_addr_%0d", k), addr, 32'h3000);
      chk($sformatf("hold_wdata_%0d", k), wdata, 32'h12345678);
      chk($sformatf("hold_wstrb_%0d", k), {28'd0, wstrb}, 32'hF);
      chk($sformatf("hold_stall_%0d", k), {31'd0, stall}, 32'd1);
    end
    cyc(); addr_ok = 1'b0; data_ok = 1'b1;
    @(negedge clk);
    chk("hold_done", {31'd0, done}, 32'd1);
    cyc(); data_ok = 1'b0; valid_i = 1'b0;

    // flush while the request is pending
    cyc(); valid_i = 1'b1; op_i = ALU_LW; addr_i = 32'h3004; addr_ok = 1'b0;
    @(negedge clk);
    cyc(); flush_i = 1'b1;
    @(negedge clk);
    chk("reqflush_stall", {31'd0, stall}, 32'd0);
    cyc(); flush_i = 1'b0; valid_i = 1'b0;
    @(negedge clk);
    chk("reqflush_req", {31'd0, req}, 32'd0);
    chk("reqflush_state", {30'd0, dbg_state}, 32'(ST_IDLE));
    chk("reqflush_done", {31'd0, done}, 32'd0);

    // flush in WAIT, then a new load arrives before the stale response
    cyc(); valid_i = 1'b1; op_i = ALU_LW; addr_i = 32'h4000; addr_ok = 1'b1;
    @(negedge clk);
    cyc(); addr_ok = 1'b0; valid_i = 1'b0; flush_i = 1'b1;
    @(negedge clk);
    cyc(); flush_i = 1'b0; valid_i = 1'b1; addr_i = 32'h4100;
    @(negedge clk);
    chk("drain_state", {30'd0, dbg_state}, 32'(ST_DRAIN));
    chk("drain_req", {31'd0, req}, 32'd0);
    chk("drain_stall", {31'd0, stall}, 32'd1);
    cyc(); data_ok = 1'b1; rdata = 32'hBAD0BAD0;
    @(negedge clk);
    chk("drain_stale_done", {31'd0, done}, 32'd0);
    chk("drain_stale_req", {31'd0, req}, 32'd0);
    cyc(); data_ok = 1'b0; addr_ok = 1'b1;
    @(negedge clk);
    chk("drain_new_req", {31'd0, req}, 32'd1);
    chk("drain_new_addr", addr, 32'h4100);
    cyc(); addr_ok = 1'b0; data_ok = 1'b1; rdata = 32'h11223344;
    @(negedge clk);
    chk("drain_new_done", {31'd0, done}, 32'd1);
    chk("drain_new_data", load_data, 32'h11223344);
    cyc(); data_ok = 1'b0; valid_i = 1'b0;

    // excepted and non-memory ops pass through
    cyc(); valid_i = 1'b1; op_i = ALU_SW; addr_i = 32'h10; exception_i = 4'd4;
    @(negedge clk);
    chk("exc_ctrl", {29'd0, req, stall, done}, 32'd0);
    cyc(); op_i = ALU_ADD; exception_i = 4'd0;
    @(negedge clk);
    chk("nonmem_ctrl", {29'd0, req, stall, done}, 32'd0);

    // asynchronous reset while waiting for data
    cyc(); op_i = ALU_LW; addr_i = 32'h5000; addr_ok = 1'b1;
    @(negedge clk);
    cyc(); addr_ok = 1'b0;
    #1 rst = 1'b0;
    #1;
    chk("rst_wait_ctrl", {22'd0, req, wr, done, stall, size, wstrb, dbg_state}, 32'd0);
    chk("rst_wait_addr", addr, 32'd0);
    chk("rst_wait_load", load_data, 32'd0);
    cyc(); valid_i = 1'b0;
    cyc(); rst = 1'b1;

    // randomized traffic against the model
    resp_auto = 1'b1;
    sb_on = 1'b1;
    for (int i = 0; i < 200; i++) begin
      int          kind;
      logic [5:0]  op;
      logic [31:0] a, wd;
      logic [3:0]  ex;
      bit          ok;
      kind = $urandom_range(0, 9);
      op   = mem_ops[$urandom_range(0, 7)];
      a    = $urandom;
      wd   = $urandom;
      ex   = 4'd0;
      if (op_size(op) == SZ_HALF) a[0] = 1'b0;
      if (op_size(op) == SZ_WORD) a[1:0] = 2'b00;
      if (kind == 8) op = ALU_ADD;
      if (kind == 9) ex = 4'($urandom_range(1, 15));
      cyc();
      valid_i = 1'b1; op_i = op; addr_i = a; wdata_i = wd; exception_i = ex;
      if (kind < 8) begin
        req_q.push_back(model_req(op, a, wd));
        lop_q.push_back(op);
        la_q.push_back(a);
        ok = 1'b0;
        for (int c = 0; c < 40; c++) begin
          @(negedge clk);
          if (!stall) begin ok = 1'b1; break; end
        end
        if (!ok) fail("accept_timeout");
      end else begin
        @(negedge clk);
        chk("rand_pass_ctrl", {29'd0, req, stall, done}, 32'd0);
      end
      if ($urandom_range(0, 3) == 0) begin
        cyc(); valid_i = 1'b0;
        @(negedge clk);
      end
    end
    cyc(); valid_i = 1'b0; exception_i = 4'd0;
    repeat (6) @(negedge clk);
    chk("end_req_q_empty", 32'(req_q.size()), 32'd0);
    chk("end_exp_q_empty", 32'(exp_q.size()), 32'd0);
    chk("end_lop_q_empty", 32'(lop_q.size()), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: got stuck expected finish");
    $fatal(1);
  end

endmodule
